// File: rtl/sram_port0_req_ctrl.sv
// Valid/ready request front-end for RW port 0 of a 32x512 OpenRAM macro.
// Registers the macro inputs, captures dout0 at its single valid edge and returns reads in order.
module sram_port0_req_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W:0]   PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic                  rd_s1_q, rd_s2_q;
    logic [PTR_W:0]        wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];
    logic [CNT_W-1:0]      count, pending;
    logic                  accept, push, pop;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // req_ready is 1 for writes; for reads it requires a free response credit, computed from
    // registered state only, so a pop frees its credit one cycle later.
    assign count     = wr_ptr_q - rd_ptr_q;
    assign pending   = count + {{(CNT_W-1){1'b0}}, rd_s1_q} + {{(CNT_W-1){1'b0}}, rd_s2_q};
    assign req_ready = req_we | (pending < DEPTH_C);
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (wr_ptr_q != rd_ptr_q);
    assign rsp_rdata = fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign pop       = rsp_valid & rsp_ready;
    // rd_s2 marks the only edge at which the macro's read data is guaranteed stable.
    assign push      = rd_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
        end else if (accept) begin
            sram_csb0   <= 1'b0;
            sram_web0   <= ~req_we;
            sram_wmask0 <= req_we ? req_wmask : '0;
            sram_addr0  <= req_addr;
            sram_din0   <= req_wdata;
        end else begin
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_s1_q <= 1'b0;
            rd_s2_q <= 1'b0;
        end else begin
            rd_s1_q <= accept & ~req_we;
            rd_s2_q <= rd_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q[PTR_W-1:0]] <= sram_dout0;
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            assert (count != DEPTH_C) else $error("response FIFO push while full");
        end
    end
endmodule

// File: tb/tb_sram_port0_req_ctrl.sv
// Bench for sram_port0_req_ctrl: behavioural SRAM macro plus a transaction-level reference model
// (memory array and expected-response queue) checked every cycle with immediate assertions.
module tb_sram_port0_req_ctrl;
    localparam int AW = 9, DW = 32, MW = 4, DEPTH = 2;

    logic          clk = 1'b0, rst_n = 1'b1;
    logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [MW-1:0] req_wmask = '0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, rsp_valid, sram_csb0, sram_web0;
    logic [DW-1:0] rsp_rdata, sram_din0, sram_dout0;
    logic [MW-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;

    always #5 clk = ~clk;

    sram_port0_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .sram_csb0(sram_csb0), .sram_web0(sram_web0),
        .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_dout0(sram_dout0)
    );

    int checks = 0, fails = 0, cyc = 0, n_pop = 0;
    bit in_rst = 1'b1;
    logic [DW-1:0] mac_mem [512];
    logic [DW-1:0] ref_mem [512];
    logic [DW-1:0] exp_q [$];
    int            exp_t [$];
    logic          exp_csb = 1'b1, exp_web = 1'b1;
    logic [MW-1:0] exp_wmask = '0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_din = '0;

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] nw, logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Macro model: samples at posedge, writes at the next negedge, read data valid from just after
    // that negedge until the next posedge, unknown otherwise.
    logic          m_csb = 1'b1, m_web = 1'b1;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    logic [MW-1:0] m_wmask;
    initial sram_dout0 = 'x;
    always @(posedge clk) begin
        m_csb = sram_csb0; m_web = sram_web0; m_addr = sram_addr0;
        m_din = sram_din0; m_wmask = sram_wmask0;
        sram_dout0 <= 'x;
    end
    always @(negedge clk) begin
        if (!m_csb) begin
            if (!m_web) mac_mem[m_addr] = merge(mac_mem[m_addr], m_din, m_wmask);
            else begin
                #1;
                sram_dout0 = mac_mem[m_addr];
            end
        end
    end

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] expd);
        checks++;
        assert (obs === expd) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, expd);
        end
    endtask

    function automatic bit exp_valid();
        return exp_t.size() > 0 && exp_t[0] <= cyc;
    endfunction

    // One clock: check outputs at negedge against the model, then advance the model at posedge.
    task automatic tick(output bit acc);
        bit ev, er, pop;
        @(negedge clk);
        ev = exp_valid();
        er = req_we || (exp_q.size() < DEPTH);
        chk("req_ready", {31'b0, req_ready}, {31'b0, er});
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, ev});
        if (ev) chk("rsp_rdata", rsp_rdata, exp_q[0]);
        chk("csb0", {31'b0, sram_csb0}, {31'b0, exp_csb});
        chk("web0", {31'b0, sram_web0}, {31'b0, exp_web});
        if (!exp_csb) begin
            chk("addr0", {23'b0, sram_addr0}, {23'b0, exp_addr});
            chk("wmask0", {28'b0, sram_wmask0}, {28'b0, exp_wmask});
            chk("din0", sram_din0, exp_din);
        end
        acc = !in_rst && req_valid && er;
        pop = !in_rst && ev && rsp_ready;
        @(posedge clk);
        cyc++;
        if (pop) begin
            void'(exp_q.pop_front());
            void'(exp_t.pop_front());
            n_pop++;
        end
        if (acc) begin
            if (req_we) ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_wmask);
            else begin
                exp_q.push_back(ref_mem[req_addr]);
                exp_t.push_back(cyc + 2);
            end
            exp_csb = 1'b0; exp_web = !req_we; exp_wmask = req_we ? req_wmask : '0;
            exp_addr = req_addr; exp_din = req_wdata;
        end else begin
            exp_csb = 1'b1; exp_web = 1'b1;
        end
        #1;
    endtask

    task automatic do_req(bit we, logic [AW-1:0] a, logic [DW-1:0] d, logic [MW-1:0] m);
        bit acc;
        acc = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
        for (int i = 0; i < 20 && !acc; i++) tick(acc);
        checks++;
        assert (acc) else begin
            fails++;
            $error("FAIL req_timeout: addr %h not accepted within 20 cycles", a);
        end
    endtask

    task automatic idle(int n);
        bit acc;
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    task automatic wait_rsp(string tag, int acc_cyc, logic [DW-1:0] expd);
        bit acc;
        req_valid = 1'b0;
        for (int i = 0; i < 10 && rsp_valid !== 1'b1; i++) tick(acc);
        chk({tag, "_latency"}, cyc - acc_cyc, 2);
        chk({tag, "_data"}, rsp_rdata, expd);
    endtask

    initial begin
        int acc_cyc, pops0;
        bit acc;
        for (int i = 0; i < 512; i++) begin
            mac_mem[i] = $urandom;
            ref_mem[i] = mac_mem[i];
        end
        #1 rst_n = 1'b0;
        #2;
        chk("rst_csb0", {31'b0, sram_csb0}, 1);
        chk("rst_web0", {31'b0, sram_web0}, 1);
        chk("rst_wmask0", {28'b0, sram_wmask0}, 0);
        chk("rst_addr0", {23'b0, sram_addr0}, 0);
        chk("rst_din0", sram_din0, 0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        idle(2);
        rst_n = 1'b1; in_rst = 1'b0;
        idle(1);

        // Write then read same address in the next cycle.
        rsp_ready = 1'b1;
        do_req(1'b1, 9'h005, 32'hDEADBEEF, 4'hF);
        do_req(1'b0, 9'h005, 32'h0, 4'h0);
        acc_cyc = cyc;
        wait_rsp("t2", acc_cyc, 32'hDEADBEEF);
        idle(2);

        // Byte-masked overwrite.
        do_req(1'b1, 9'h1FF, 32'h11223344, 4'hF);
        do_req(1'b1, 9'h1FF, 32'hAABBCCDD, 4'b0101);
        do_req(1'b0, 9'h1FF, 32'h0, 4'h0);
        acc_cyc = cyc;
        wait_rsp("t3", acc_cyc, 32'h11BB33DD);
        idle(2);

        // Back-to-back reads, all responses in order.
        pops0 = n_pop;
        for (int i = 0; i < 8; i++) do_req(1'b0, AW'(i), 32'h0, 4'h0);
        idle(8);
        chk("t4_responses", rsp_valid, 0);
        checks++;
        assert (n_pop - pops0 == 8) else begin
            fails++;
            $error("FAIL t4_count: got %0d responses expected 8", n_pop - pops0);
        end

        // Backpressure: credit stalls reads but not writes.
        rsp_ready = 1'b0;
        do_req(1'b0, 9'h1FF, 32'h0, 4'h0);
        do_req(1'b0, 9'h005, 32'h0, 4'h0);
        req_addr = 9'h000; req_we = 1'b0;
        for (int i = 0; i < 4; i++) tick(acc);
        chk("t5_blocked", {31'b0, req_ready}, 0);
        do_req(1'b1, 9'h010, 32'hCAFEF00D, 4'hF);
        rsp_ready = 1'b1;
        do_req(1'b0, 9'h000, 32'h0, 4'h0);
        do_req(1'b0, 9'h010, 32'h0, 4'h0);
        idle(8);
        chk("t5_drained", {31'b0, rsp_valid}, 0);

        // Idle with one held response.
        rsp_ready = 1'b0;
        do_req(1'b0, 9'h003, 32'h0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk("t6_no_x", {31'b0, ^rsp_rdata === 1'bx}, 0);
        end
        rsp_ready = 1'b1;
        idle(2);

        // Randomized mix with random backpressure.
        for (int i = 0; i < 300; i++) begin
            req_valid = $urandom_range(0, 3) != 0;
            req_we = $urandom_range(0, 1) == 1;
            req_addr = AW'($urandom_range(0, 15));
            req_wdata = $urandom;
            req_wmask = MW'($urandom_range(0, 15));
            rsp_ready = $urandom_range(0, 3) != 0;
            tick(acc);
        end
        rsp_ready = 1'b1;
        idle(6);

        // Reset with reads in flight: outputs return to idle without a clock edge.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h003;
        tick(acc);
        tick(acc);
        rst_n = 1'b0;
        #1;
        chk("t1_csb0", {31'b0, sram_csb0}, 1);
        chk("t1_web0", {31'b0, sram_web0}, 1);
        chk("t1_rsp_valid", {31'b0, rsp_valid}, 0);
        exp_q.delete(); exp_t.delete();
        exp_csb = 1'b1; exp_web = 1'b1; exp_wmask = '0; exp_addr = '0; exp_din = '0;
        in_rst = 1'b1;
        idle(3);
        rst_n = 1'b1; in_rst = 1'b0;
        idle(3);
        chk("t1_no_replay", {31'b0, rsp_valid}, 0);
        rsp_ready = 1'b1;
        do_req(1'b0, 9'h1FF, 32'h0, 4'h0);
        idle(6);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
